// File: rtl/hex_to_ascii_tx_if.sv
// Word-in / char-out handshake bundle for hex_to_ascii_tx; W must equal 4*DIGITS of the attached block.
// slave = printer side, master = word source plus UART byte sink.
interface hex_to_ascii_tx_if #(
    parameter int W = 32
);
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic [7:0]   char_out;
    logic         char_valid;
    logic         char_ready;
    logic         busy;

    modport slave (
        input  word_in, word_valid, char_ready,
        output word_ready, char_out, char_valid, busy
    );

    modport master (
        output word_in, word_valid, char_ready,
        input  word_ready, char_out, char_valid, busy
    );
endinterface

// File: rtl/hex_to_ascii_tx.sv
// Prints a DIGITS-nibble word as uppercase ASCII hex, MS nibble first; HEX_TO_ASCII_TX_CRLF_EN appends CR LF.
// Latency: first char valid the cycle after word accept, then one char per cycle while char_ready is high.
// Backpressure: char_ready low freezes char_out/sreg/cnt/state; word_ready only in IDLE, words elsewhere dropped.
module hex_to_ascii_tx #(
    parameter  int DIGITS = 8,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    hex_to_ascii_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        DIGIT
`ifdef HEX_TO_ASCII_TX_CRLF_EN
        , CR,
        LF
`endif
    } state_t;

    state_t        state;
    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sreg_shl;

    // Next character comes from the nibble below the current top one.
    assign sreg_shl = sreg << 4;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sreg           <= '0;
            cnt            <= '0;
            bus.char_out   <= 8'h00;
            bus.char_valid <= 1'b0;
            bus.word_ready <= 1'b1;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.word_valid && bus.word_ready) begin
                        sreg           <= bus.word_in;
                        cnt            <= CW'(DIGITS - 1);
                        bus.char_out   <= hex_char(bus.word_in[W-1 -: 4]);
                        bus.char_valid <= 1'b1;
                        bus.word_ready <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (bus.char_valid && bus.char_ready) begin
                        if (cnt != '0) begin
                            sreg         <= sreg_shl;
                            cnt          <= cnt - CW'(1);
                            bus.char_out <= hex_char(sreg_shl[W-1 -: 4]);
                        end else begin
`ifdef HEX_TO_ASCII_TX_CRLF_EN
                            bus.char_out <= 8'h0D;
                            state        <= CR;
`else
                            bus.char_valid <= 1'b0;
                            bus.word_ready <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
`endif
                        end
                    end
                end
`ifdef HEX_TO_ASCII_TX_CRLF_EN
                CR: begin
                    if (bus.char_valid && bus.char_ready) begin
                        bus.char_out <= 8'h0A;
                        state        <= LF;
                    end
                end
                LF: begin
                    if (bus.char_valid && bus.char_ready) begin
                        bus.char_valid <= 1'b0;
                        bus.word_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end
`endif
                default: begin
                    bus.char_valid <= 1'b0;
                    bus.word_ready <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_to_ascii_tx.sv
// Directed + random bench for hex_to_ascii_tx: character scoreboard queue, receive-side decode of every char.
module tb_hex_to_ascii_tx;
    localparam int DIGITS = 8;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst_n;

    hex_to_ascii_tx_if #(.W(W)) bus  ();
    hex_to_ascii_tx_if #(.W(8)) bus2 ();
    hex_to_ascii_tx_if #(.W(4)) bus1 ();

    hex_to_ascii_tx #(.DIGITS(DIGITS)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus));
    hex_to_ascii_tx #(.DIGITS(2))      u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    hex_to_ascii_tx #(.DIGITS(1))      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [W-1:0] rx_word;
    bit          dec_bad;

    function automatic logic [7:0] exp_char(input logic [3:0] n);
        string s = "0123456789ABCDEF";
        return s[n];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = DIGITS - 1; i >= 0; i--) exp_q.push_back(exp_char(w[4*i +: 4]));
`ifdef HEX_TO_ASCII_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // One clock: score any handshake seen mid-cycle, then step to just after the next rising edge.
    task automatic tick();
        logic [7:0] c;
        logic [7:0] e;
        @(negedge clk);
        if (rst_n && bus.char_valid && bus.char_ready) begin
            c = bus.char_out;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL extra_char observed=%0h expected=none", c);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("char", {56'h0, c}, {56'h0, e});
            end
            if (c >= 8'h30 && c <= 8'h39)      rx_word = {rx_word[W-5:0], 4'(c - 8'h30)};
            else if (c >= 8'h41 && c <= 8'h46) rx_word = {rx_word[W-5:0], 4'(c - 8'h41 + 8'd10)};
            else if (c != 8'h0D && c != 8'h0A) dec_bad = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        check("send_word_ready", {63'h0, bus.word_ready}, 64'h1);
        push_word(w);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.word_ready) && n < 200) begin
            if (rnd) bus.char_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.char_ready = 1'b1;
        check("drain_timeout", {63'h0, (n < 200)}, 64'h1);
    endtask

    initial begin
        logic [7:0] e2[$];
        logic [W-1:0] w;
        rst_n           = 1'b0;
        bus.word_in     = '0;  bus.word_valid  = 1'b0; bus.char_ready  = 1'b1;
        bus2.word_in    = '0;  bus2.word_valid = 1'b0; bus2.char_ready = 1'b1;
        bus1.word_in    = '0;  bus1.word_valid = 1'b0; bus1.char_ready = 1'b1;
        rx_word         = '0;
        dec_bad         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_char_valid", {63'h0, bus.char_valid}, 64'h0);
        check("rst_busy",       {63'h0, bus.busy},       64'h0);
        check("rst_word_ready", {63'h0, bus.word_ready}, 64'h1);
        check("rst_char_out",   {56'h0, bus.char_out},   64'h0);
        rst_n = 1'b1;
        tick();

        // Full-rate word: one char per cycle, word_ready low until the 9th cycle.
        send_word(32'h1234ABCD);
        for (int k = 0; k < DIGITS; k++) begin
            check("run_word_ready", {63'h0, bus.word_ready}, 64'h0);
            check("run_char_valid", {63'h0, bus.char_valid}, 64'h1);
            check("run_busy",       {63'h0, bus.busy},       64'h1);
            tick();
        end
`ifndef HEX_TO_ASCII_TX_CRLF_EN
        check("end_word_ready", {63'h0, bus.word_ready}, 64'h1);
        check("end_busy",       {63'h0, bus.busy},       64'h0);
        check("end_queue_empty", 64'(exp_q.size()), 64'h0);
`endif
        drain(1'b0);
        check("rx_1234ABCD", 64'(rx_word), 64'h1234ABCD);

        // Backpressure on the second character.
        send_word(32'h0000000F);
        tick();
        bus.char_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_char_out",   {56'h0, bus.char_out},   64'h30);
            check("stall_char_valid", {63'h0, bus.char_valid}, 64'h1);
            tick();
        end
        check("stall_char_out_last", {56'h0, bus.char_out}, 64'h30);
        bus.char_ready = 1'b1;
        drain(1'b0);
        check("rx_0000000F", 64'(rx_word), 64'h0000000F);

        // A word offered while busy must never be printed.
        send_word(32'h01234567);
        tick();
        bus.word_in    = 32'hFFFFFFFF;
        bus.word_valid = 1'b1;
        repeat (3) tick();
        bus.word_valid = 1'b0;
        drain(1'b0);
        check("rx_01234567", 64'(rx_word), 64'h01234567);
        for (int k = 0; k < 3; k++) begin
            check("idle_after_ignored", {63'h0, bus.char_valid}, 64'h0);
            tick();
        end

        // Reset after the third handshake drops the rest of the word.
        send_word(32'hDEADBEEF);
        repeat (3) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_char_valid", {63'h0, bus.char_valid}, 64'h0);
        check("midrst_busy",       {63'h0, bus.busy},       64'h0);
        check("midrst_word_ready", {63'h0, bus.word_ready}, 64'h1);
        check("midrst_char_out",   {56'h0, bus.char_out},   64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_no_resume", {63'h0, bus.char_valid}, 64'h0);
        send_word(32'h00000001);
        drain(1'b0);
        check("rx_00000001", 64'(rx_word), 64'h00000001);

        // DIGITS=2 instance, cycle-exact.
        e2 = {8'h41, 8'h35};
`ifdef HEX_TO_ASCII_TX_CRLF_EN
        e2.push_back(8'h0D);
        e2.push_back(8'h0A);
`endif
        bus2.word_in    = 8'hA5;
        bus2.word_valid = 1'b1;
        tick();
        bus2.word_valid = 1'b0;
        foreach (e2[k]) begin
            check("d2_char_valid", {63'h0, bus2.char_valid}, 64'h1);
            check("d2_char_out",   {56'h0, bus2.char_out},   {56'h0, e2[k]});
            check("d2_word_ready", {63'h0, bus2.word_ready}, 64'h0);
            tick();
        end
        check("d2_end_word_ready", {63'h0, bus2.word_ready}, 64'h1);
        check("d2_end_char_valid", {63'h0, bus2.char_valid}, 64'h0);

        // DIGITS=1 instance: one character, then straight back to IDLE.
        bus1.word_in    = 4'hB;
        bus1.word_valid = 1'b1;
        tick();
        bus1.word_valid = 1'b0;
        check("d1_char_out",   {56'h0, bus1.char_out},   64'h42);
        check("d1_char_valid", {63'h0, bus1.char_valid}, 64'h1);
        check("d1_busy",       {63'h0, bus1.busy},       64'h1);
`ifdef HEX_TO_ASCII_TX_CRLF_EN
        repeat (2) tick();
`endif
        tick();
        check("d1_end_word_ready", {63'h0, bus1.word_ready}, 64'h1);
        check("d1_end_busy",       {63'h0, bus1.busy},       64'h0);

        // Round trip of random words through the receive-side decode, random backpressure.
        for (int n = 0; n < 1000; n++) begin
            w = W'($urandom());
            send_word(w);
            drain(1'b1);
            check("roundtrip", 64'(rx_word), 64'(w));
        end
        check("decode_all_valid", {63'h0, dec_bad}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_to_ascii_tx.md
Name: hex_to_ascii_tx

Overview:
- Converts a parallel binary word into a stream of ASCII hex characters, most significant nibble first.
- Each character is handed to the UART transmitter byte interface over a valid/ready handshake.
- It is the transmit-side counterpart of the ASCII-to-hex decode on the receive path.
- Uses only uppercase digits '0'-'9' and 'A'-'F', so the receive-side decoder accepts every emitted character.

Parameters:
- DIGITS, 8: number of hex characters per word; legal range 1..16.
- W, 4*DIGITS: input word width; derived from DIGITS, not to be overridden.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- word_in  in  W  binary word to print.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  block can accept a word; high only in IDLE.
- char_out  out  8  ASCII character to the UART transmitter.
- char_valid  out  1  char_out is valid.
- char_ready  in  1  UART transmitter accepts char_out.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low; clock port is clk, reset port is rst_n.
- Reset values: state=IDLE, char_out=8'h00, char_valid=0, busy=0, word_ready=1, shift register=0, digit counter=0.
- Nibble mapping: 0..9 -> 8'h30..8'h39; A..F -> 8'h41..8'h46. No lowercase output.
- Registers: W-bit shift register sreg; digit counter cnt of width clog2(DIGITS+1).
- FSM states: IDLE, DIGIT, CR, LF. CR and LF exist only when CRLF_EN is defined.
- IDLE: word_ready=1.
  - On word_valid && word_ready: capture sreg<=word_in, cnt<=DIGITS-1.
  - Set char_out<=map(word_in[W-1:W-4]) and char_valid<=1, then go to DIGIT.
  - Latency: the first character is valid on the cycle after the accepting edge.
- DIGIT, on handshake (char_valid && char_ready):
  - If cnt!=0: shift sreg left by 4, cnt<=cnt-1, char_out<=map(next top nibble); char_valid stays 1. Result is one character per cycle when char_ready is held high.
  - If cnt==0: without CRLF_EN, char_valid<=0 and go to IDLE. With CRLF_EN, char_out<=8'h0D and go to CR.
- Backpressure: while char_valid=1 and char_ready=0, char_out, sreg, cnt and state hold exactly.
- Ignored inputs: word_valid and word_in are ignored outside IDLE. No queueing; the word is not latched later.
- No overlap: word_ready rises only on the cycle after the final character handshake. With char_ready tied high, one DIGITS-character word costs DIGITS+1 cycles.
- DIGITS=1: the single character is emitted and the block returns to IDLE after one handshake.
- char_ready while char_valid=0: ignored.
- Reset mid-word: every register returns to its reset value immediately (asynchronous). The partial word is dropped; nothing resumes after reset release.

Optional Feature:
- Macro: HEX_TO_ASCII_TX_CRLF_EN
- Defined:
  - After the last digit, the block emits 8'h0D (state CR), then 8'h0A (state LF), each under the same handshake and backpressure rules.
  - LF handshake -> char_valid<=0 and go to IDLE.
  - Throughput with char_ready high: DIGITS+3 cycles per word.
- Undefined: the CR and LF states and their logic are absent; the block emits digits only.

Test Plan:
- Reset then DIGITS=8, word_in=32'h1234ABCD, char_ready=1 -> char_out 31,32,33,34,41,42,43,44 on 8 consecutive cycles starting the cycle after accept; word_ready=0 throughout, high on the 9th cycle.
- Word 32'h0000000F with char_ready low for 3 cycles on the 2nd character -> 8'h30 held stable for 4 cycles, full sequence 30,30,30,30,30,30,30,46 with no loss or duplication.
- word_valid pulsed with 32'hFFFFFFFF while busy printing 32'h01234567 -> output is exactly 30..37; the second word is never printed.
- rst_n low for 1 cycle after the 3rd handshake of 32'hDEADBEEF -> char_valid=0, busy=0, word_ready=1 at once; after release, 32'h00000001 prints cleanly as seven 30 then 31.
- CRLF_EN defined, DIGITS=2, word 8'hA5 -> 41,35,0D,0A, then IDLE; 5 cycles per word.
- Round trip: random words through this block, each character fed to the ASCII-to-hex decoder and reassembled -> matches the original word for 1000 words.
